// File: rtl/c_pkg.sv
// rtl/c_pkg.sv - shared types and helpers for the pipelined unary/thermometer checker
package c_pkg;

   localparam int C_W_MAX  = 64;
   localparam int C_CNT_W  = 8;

   // seen = zero_seen (normal lane) or one_seen (complement lane)
   typedef struct packed {
      logic               seen;
      logic               bad;
      logic [C_CNT_W-1:0] cnt;
   } c_lane_t;

   localparam int C_LANE_W = $bits(c_lane_t);

   typedef struct packed {
      logic               valid;
      c_lane_t            lane_norm;
      c_lane_t            lane_comp;
      logic [C_W_MAX-1:0] rem_x;
   } c_stage_t;

   function automatic int c_vw(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/c_pipe_stage.sv
// rtl/c_pipe_stage.sv - combinational update of both scan lanes from one chunk
module c_pipe_stage
   import c_pkg::*;
#(
   parameter int CW                    = 4,
   parameter int VW                    = 5,
   parameter int P_ADMIT_COMPLIMENT_EN = 1
) (
   input  logic [CW-1:0]       chunk,
   input  logic [C_LANE_W-1:0] norm_in,
   input  logic [C_LANE_W-1:0] comp_in,
   output logic [C_LANE_W-1:0] norm_out,
   output logic [C_LANE_W-1:0] comp_out
);

   if (VW > C_CNT_W) begin : g_bad_vw
      $error("c_pipe_stage: VW exceeds lane counter width");
   end

   c_lane_t n;
   c_lane_t c;

   always_comb begin
      n = c_lane_t'(norm_in);
      c = c_lane_t'(comp_in);
      for (int i = 0; i < CW; i++) begin
         // normal lane counts leading (LSB-side) ones; a one after a zero is illegal
         if (chunk[i]) begin
            if (n.seen) n.bad = 1'b1;
            else        n.cnt = n.cnt + C_CNT_W'(1);
         end else begin
            n.seen = 1'b1;
         end
         if (!chunk[i]) begin
            if (c.seen) c.bad = 1'b1;
            else        c.cnt = c.cnt + C_CNT_W'(1);
         end else begin
            c.seen = 1'b1;
         end
      end
      norm_out = n;
      comp_out = (P_ADMIT_COMPLIMENT_EN != 0) ? c : '0;
   end

endmodule

// File: rtl/c_pipe.sv
// rtl/c_pipe.sv - pipelined, flow-controlled unary/thermometer admission checker
module c_pipe
   import c_pkg::*;
#(
   parameter  int W                     = 16,
   parameter  int P_STAGES              = 4,
   parameter  int P_ADMIT_COMPLIMENT_EN = 1,
   localparam int CW                    = W / P_STAGES,
   localparam int VW                    = c_vw(W)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_valid,
   input  logic [W-1:0]  i_x,
   output logic          o_ready,
   output logic          o_valid,
   input  logic          i_ready,
   output logic          o_is_unary,
   output logic          o_is_compliment,
   output logic [VW-1:0] o_value
);

   if ((W % P_STAGES) != 0 || W < 2 || W > C_W_MAX) begin : g_bad_cfg
      $error("c_pipe: W must be >= 2, <= C_W_MAX and a multiple of P_STAGES");
   end

   logic     adv;
   c_stage_t in_stage;

   // one global enable: the whole pipe freezes while the consumer stalls
   assign adv     = !o_valid | i_ready;
   assign o_ready = adv;

   always_comb begin
      in_stage              = '0;
      in_stage.valid        = i_valid;
      in_stage.rem_x[W-1:0] = i_x;
   end

   for (genvar k = 0; k < P_STAGES; k++) begin : g_stage
      c_stage_t            cur;
      c_stage_t            q;
      logic [C_LANE_W-1:0] norm_nxt;
      logic [C_LANE_W-1:0] comp_nxt;

      if (k == 0) begin : g_first
         assign cur = in_stage;
      end else begin : g_next
         assign cur = g_stage[k-1].q;
      end

      c_pipe_stage #(
         .CW                    (CW),
         .VW                    (VW),
         .P_ADMIT_COMPLIMENT_EN (P_ADMIT_COMPLIMENT_EN)
      ) u_stage (
         .chunk    (cur.rem_x[k*CW +: CW]),
         .norm_in  (cur.lane_norm),
         .comp_in  (cur.lane_comp),
         .norm_out (norm_nxt),
         .comp_out (comp_nxt)
      );

      always_ff @(posedge clk) begin
         if (rst) begin
            q <= '0;
         end else if (adv) begin
            q.valid     <= cur.valid;
            q.lane_norm <= c_lane_t'(norm_nxt);
            q.lane_comp <= c_lane_t'(comp_nxt);
            q.rem_x     <= cur.rem_x;
         end
      end
   end

   c_stage_t fin;
   logic     norm_ok;
   logic     comp_ok;
   logic     unused_fin;

   assign fin = g_stage[P_STAGES-1].q;

   // resolve from the last stage register; gating with valid keeps idle outputs at 0
   assign norm_ok = fin.valid & !fin.lane_norm.bad;
   assign comp_ok = fin.valid & (P_ADMIT_COMPLIMENT_EN != 0) & !fin.lane_comp.bad
                    & fin.lane_comp.seen & (fin.lane_comp.cnt != '0);

   assign o_valid         = fin.valid;
   assign o_is_unary      = norm_ok | comp_ok;
   assign o_is_compliment = !norm_ok & comp_ok;
   assign o_value         = norm_ok ? fin.lane_norm.cnt[VW-1:0] :
                            comp_ok ? fin.lane_comp.cnt[VW-1:0] : '0;

   assign unused_fin = ^{fin.rem_x, fin.lane_norm.cnt, fin.lane_comp.cnt};

endmodule

// File: tb/tb_c_pipe.sv
// tb/tb_c_pipe.sv - directed self-checking bench for c_pipe
module tb_c_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_valid;
   logic [15:0] i_x;
   logic        i_ready;
   logic        o_ready, o_valid, o_is_unary, o_is_compliment;
   logic [4:0]  o_value;
   logic        d0_ready, d0_valid, d0_is_unary, d0_is_compliment;
   logic [4:0]  d0_value;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   c_pipe #(.W(16), .P_STAGES(4), .P_ADMIT_COMPLIMENT_EN(1)) dut (
      .clk(clk), .rst(rst), .i_valid(i_valid), .i_x(i_x), .o_ready(o_ready),
      .o_valid(o_valid), .i_ready(i_ready), .o_is_unary(o_is_unary),
      .o_is_compliment(o_is_compliment), .o_value(o_value)
   );

   c_pipe #(.W(16), .P_STAGES(4), .P_ADMIT_COMPLIMENT_EN(0)) dut_nc (
      .clk(clk), .rst(rst), .i_valid(i_valid), .i_x(i_x), .o_ready(d0_ready),
      .o_valid(d0_valid), .i_ready(i_ready), .o_is_unary(d0_is_unary),
      .o_is_compliment(d0_is_compliment), .o_value(d0_value)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_res(input string tag, input logic v, input logic u, input logic c,
                          input logic [4:0] val);
      chk({tag, ".valid"}, o_valid, v);
      chk({tag, ".unary"}, o_is_unary, u);
      chk({tag, ".compl"}, o_is_compliment, c);
      chk({tag, ".value"}, o_value, val);
   endtask

   logic [15:0] vec [4];
   logic [6:0]  exp_r [4];   // {unary, compl, value}
   logic [15:0] bp_vec [6];
   int          sent, recv;
   logic        acc_in, acc_out;

   initial begin
      rst = 1'b1; i_valid = 1'b0; i_x = '0; i_ready = 1'b1;
      step(); step();
      rst = 1'b0;
      #1;
      chk_res("reset", 1'b0, 1'b0, 1'b0, 5'd0);
      chk("reset.ready", o_ready, 1'b1);

      // basic codes, back to back
      vec[0] = 16'h00FF; exp_r[0] = {1'b1, 1'b0, 5'd8};
      vec[1] = 16'hFF00; exp_r[1] = {1'b1, 1'b1, 5'd8};
      vec[2] = 16'h0F0F; exp_r[2] = {1'b0, 1'b0, 5'd0};
      for (int i = 0; i < 7; i++) begin
         i_valid = (i < 3); i_x = (i < 3) ? vec[i] : 16'h0;
         step();
         if (i >= 3 && i < 6)
            chk_res($sformatf("basic%0d", i - 3), 1'b1, exp_r[i-3][6], exp_r[i-3][5], exp_r[i-3][4:0]);
         else if (i == 6)
            chk("basic.drain", o_valid, 1'b0);
      end

      // boundaries
      vec[0] = 16'h0000; exp_r[0] = {1'b1, 1'b0, 5'd0};
      vec[1] = 16'hFFFF; exp_r[1] = {1'b1, 1'b0, 5'd16};
      vec[2] = 16'h8000; exp_r[2] = {1'b1, 1'b1, 5'd15};
      vec[3] = 16'h0001; exp_r[3] = {1'b1, 1'b0, 5'd1};
      for (int i = 0; i < 8; i++) begin
         i_valid = (i < 4); i_x = (i < 4) ? vec[i] : 16'h0;
         step();
         if (i >= 3 && i < 7)
            chk_res($sformatf("bound%0d", i - 3), 1'b1, exp_r[i-3][6], exp_r[i-3][5], exp_r[i-3][4:0]);
      end

      // complement disabled instance
      vec[0] = 16'hFF00; exp_r[0] = {1'b0, 1'b0, 5'd0};
      vec[1] = 16'h7FFF; exp_r[1] = {1'b1, 1'b0, 5'd15};
      for (int i = 0; i < 6; i++) begin
         i_valid = (i < 2); i_x = (i < 2) ? vec[i] : 16'h0;
         step();
         if (i >= 3 && i < 5) begin
            chk($sformatf("noc%0d.valid", i - 3), d0_valid, 1'b1);
            chk($sformatf("noc%0d.unary", i - 3), d0_is_unary, exp_r[i-3][6]);
            chk($sformatf("noc%0d.compl", i - 3), d0_is_compliment, exp_r[i-3][5]);
            chk($sformatf("noc%0d.value", i - 3), d0_value, exp_r[i-3][4:0]);
         end
      end

      // backpressure: values 0..5 as thermometer codes
      for (int k = 0; k < 6; k++) bp_vec[k] = 16'((32'd1 << k) - 1);
      sent = 0; recv = 0;
      for (int cyc = 0; cyc < 60 && recv < 6; cyc++) begin
         i_ready = !(cyc >= 2 && cyc < 12);
         i_valid = (sent < 6);
         i_x     = (sent < 6) ? bp_vec[sent] : 16'h0;
         #1;
         acc_in  = i_valid & o_ready;
         acc_out = o_valid & i_ready;
         if (o_valid && !i_ready) begin
            chk("bp.stall_ready", o_ready, 1'b0);
            chk("bp.hold_value", o_value, 5'(recv));
         end
         if (acc_out) begin
            chk("bp.order", o_value, 5'(recv));
            chk("bp.unary", o_is_unary, 1'b1);
            recv++;
         end
         step();
         if (acc_in) sent++;
      end
      chk("bp.sent", sent, 6);
      chk("bp.recv", recv, 6);
      i_valid = 1'b0; i_ready = 1'b1;
      for (int i = 0; i < 5; i++) step();
      chk("bp.no_dup", o_valid, 1'b0);

      // bubbles: valid every other cycle
      for (int i = 0; i < 16; i++) begin
         i_valid = (i < 8) && (i % 2 == 0);
         i_x = 16'h0003;
         step();
         chk($sformatf("bubble%0d", i), o_valid, (i >= 3) && (i - 3 < 8) && ((i - 3) % 2 == 0));
      end

      // reset with three vectors in flight
      for (int i = 0; i < 3; i++) begin
         i_valid = 1'b1; i_x = 16'h00FF;
         step();
      end
      i_valid = 1'b0; rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      chk_res("rst.now", 1'b0, 1'b0, 1'b0, 5'd0);
      chk("rst.now.ready", o_ready, 1'b1);
      for (int i = 0; i < 4; i++) begin
         step();
         chk_res($sformatf("rst%0d", i), 1'b0, 1'b0, 1'b0, 5'd0);
         chk($sformatf("rst%0d.ready", i), o_ready, 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
